// File: rtl/fifo_pkg.sv
// Shared types and parameter sanity helpers for the synchronous FIFO.
package fifo_pkg;

  localparam int DefDataWidth = 8;
  localparam int DefDepth     = 16;

  // Pointer carries one extra wrap bit; count spans 0..Depth inclusive.
  typedef logic [$clog2(DefDepth):0] ptr_t;
  typedef logic [$clog2(DefDepth):0] count_t;

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit params_ok(input int depth, input int afull, input int aempty);
    return is_pow2(depth) && (depth >= 4) &&
           (afull >= 1) && (afull <= depth) &&
           (aempty >= 0) && (aempty <= depth - 1);
  endfunction

endpackage

// File: rtl/fifo_sync_ram.sv
// Simple dual-port RAM: synchronous write, registered synchronous read, no reset.
module fifo_sync_ram #(
  parameter int DataWidth = 8,
  parameter int Depth     = 16
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(Depth)-1:0] wr_addr,
  input  logic [DataWidth-1:0]     wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(Depth)-1:0] rd_addr,
  output logic [DataWidth-1:0]     rd_data
);

  logic [DataWidth-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fifo_sync_ctrl.sv
// Synchronous FIFO controller: pointers, registered flags, sticky errors, flush,
// and an optional first-word-fall-through output stage around fifo_sync_ram.
module fifo_sync_ctrl
  import fifo_pkg::*;
#(
  parameter int DataWidth   = 8,
  parameter int Depth       = 16,
  parameter int Fwft        = 0,
  parameter int AlmostFull  = 12,
  parameter int AlmostEmpty = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_flush,
  input  logic                       i_wr_en,
  input  logic [DataWidth-1:0]       i_wr_data,
  input  logic                       i_rd_en,
  output logic [DataWidth-1:0]       o_rd_data,
  output logic                       o_rd_valid,
  output logic                       o_full,
  output logic                       o_empty,
  output logic                       o_almost_full,
  output logic                       o_almost_empty,
  output logic [$clog2(Depth):0]     o_count,
  output logic                       o_overflow,
  output logic                       o_underflow
);

  localparam int AddrWidth  = $clog2(Depth);
  localparam int CountWidth = AddrWidth + 1;

  typedef logic [AddrWidth:0]    addr_ptr_t;
  typedef logic [CountWidth-1:0] occ_t;

  if (!params_ok(Depth, AlmostFull, AlmostEmpty)) begin : g_bad_cfg
    $error("fifo_sync_ctrl: Depth must be a power of 2 >= 4 and thresholds in range");
  end

  addr_ptr_t            wr_ptr, rd_ptr;
  logic                 wr_acc, rd_acc, ram_rd, empty_n;
  logic [DataWidth-1:0] ram_q;
  occ_t                 count_n;

  // Flush swallows any request issued alongside it.
  assign wr_acc  = i_wr_en & ~o_full  & ~i_flush;
  assign rd_acc  = i_rd_en & ~o_empty & ~i_flush;
  assign count_n = o_count + occ_t'(wr_acc) - occ_t'(rd_acc);

  fifo_sync_ram #(.DataWidth(DataWidth), .Depth(Depth)) u_ram (
    .clk     (i_clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr[AddrWidth-1:0]),
    .wr_data (i_wr_data),
    .rd_en   (ram_rd),
    .rd_addr (rd_ptr[AddrWidth-1:0]),
    .rd_data (ram_q)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      o_count        <= '0;
      o_empty        <= 1'b1;
      o_full         <= 1'b0;
      o_almost_full  <= 1'b0;
      o_almost_empty <= 1'b1;
      o_overflow     <= 1'b0;
      o_underflow    <= 1'b0;
    end else if (i_flush) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      o_count        <= '0;
      o_empty        <= 1'b1;
      o_full         <= 1'b0;
      o_almost_full  <= 1'b0;
      o_almost_empty <= 1'b1;
      o_overflow     <= 1'b0;
      o_underflow    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + addr_ptr_t'(1);
      if (ram_rd) rd_ptr <= rd_ptr + addr_ptr_t'(1);
      o_count        <= count_n;
      o_empty        <= empty_n;
      o_full         <= (count_n == occ_t'(Depth));
      o_almost_full  <= (count_n >= occ_t'(AlmostFull));
      o_almost_empty <= (count_n <= occ_t'(AlmostEmpty));
      if (i_wr_en & o_full)  o_overflow  <= 1'b1;
      if (i_rd_en & o_empty) o_underflow <= 1'b1;
    end
  end

  if (Fwft == 0) begin : g_std
    logic rd_vld, seen;

    // RAM output is not reset; mask it until a read has landed since reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        rd_vld <= 1'b0;
        seen   <= 1'b0;
      end else if (i_flush) begin
        rd_vld <= 1'b0;
      end else begin
        rd_vld <= rd_acc;
        if (rd_acc) seen <= 1'b1;
      end
    end

    assign ram_rd     = rd_acc;
    assign empty_n    = (count_n == '0);
    assign o_rd_valid = rd_vld;
    assign o_rd_data  = seen ? ram_q : '0;
  end else begin : g_fwft
    logic                 mid_vld, out_vld, out_load;
    logic [DataWidth-1:0] out_data;

    // mid_vld marks a RAM word sitting on ram_q, waiting to enter the output register.
    assign out_load = mid_vld & (~out_vld | rd_acc);
    assign ram_rd   = ~i_flush & (wr_ptr != rd_ptr) & (~mid_vld | out_load);
    assign empty_n  = ~(out_load | (out_vld & ~rd_acc));

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        mid_vld  <= 1'b0;
        out_vld  <= 1'b0;
        out_data <= '0;
      end else if (i_flush) begin
        mid_vld  <= 1'b0;
        out_vld  <= 1'b0;
      end else begin
        mid_vld <= ram_rd | (mid_vld & ~out_load);
        out_vld <= out_load | (out_vld & ~rd_acc);
        if (out_load) out_data <= ram_q;
      end
    end

    assign o_rd_valid = ~o_empty;
    assign o_rd_data  = out_data;
  end

endmodule
